m6809_core_fetch: RTL and testbench

- Instruction fetch/issue sequencer directly upstream of m6809_core_regmove.
- Loads PC from the reset vector, then fetches opcode and post-byte for the register-move group: EXG 1E, TFR 1F, PSHS 34, PULS 35, PSHU 36, PULU 37.
- For each such opcode it presents IR/post-byte/PC to regmove, pulses start, hands over the memory bus and waits for done.
- Accepts PC reloads (e.g. PULS PC) and traps illegal opcodes and hung executions.

---
 rtl/m6809_core_fetch.sv | 208 ++++++++++++++++++++
 tb/tb_m6809_core_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6809_core_fetch.sv
// m6809_core_fetch
// ----------------
// Instruction fetch/issue sequencer for the register-move group
// (EXG 1E, TFR 1F, PSHS 34, PULS 35, PSHU 36, PULU 37). It loads PC from the
// reset vector, fetches opcode and post-byte, presents IR/post/PC to
// m6809_core_regmove, pulses start, releases the bus and waits for done.
// NOP (12) retires in the fetch cycle. Any other opcode, or a missing done,
// traps into an absorbing HALT state.
//
// Handshake: start is a one-cycle pulse, high exactly while the FSM is in
// ISSUE. done is a one-cycle pulse sampled only in WAIT_DONE and ignored in
// every other state. pc_load_en/pc_load are sampled only in ISSUE and
// WAIT_DONE. If a load lands together with done, the loaded PC is the one
// used by the next opcode fetch.
//
// Ports:
//   clk, reset_b      clock; asynchronous active-low reset
//   addr, bus_own     fetch address, driven by this block while bus_own=1
//   data_rw_n         always 1 (fetch only reads)
//   din               memory read data for addr, sampled at clk rise
//   ir_out, post_out  latched opcode and post-byte
//   pc_out            current PC
//   start             issue pulse to regmove
//   done              regmove completion pulse
//   pc_load_en/pc_load  PC write from regmove
//   halted/illegal/timeout  sticky trap flags
//   instr_count       retired instructions (wraps)
//   state_dbg         current FSM state encoding
module m6809_core_fetch #(
  parameter logic [15:0] RESET_VECTOR    = 16'hFFFE,
  parameter int unsigned MAX_EXEC_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_b,
  output logic [15:0] addr,
  output logic        data_rw_n,
  output logic        bus_own,
  input  logic [7:0]  din,
  output logic [7:0]  ir_out,
  output logic [7:0]  post_out,
  output logic [15:0] pc_out,
  output logic        start,
  input  logic        done,
  input  logic        pc_load_en,
  input  logic [15:0] pc_load,
  output logic        halted,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] instr_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_VEC_HI     = 3'd0,
    ST_VEC_LO     = 3'd1,
    ST_FETCH_OP   = 3'd2,
    ST_FETCH_POST = 3'd3,
    ST_ISSUE      = 3'd4,
    ST_WAIT_DONE  = 3'd5,
    ST_HALT       = 3'd6
  } state_e;

  localparam logic [7:0]  OP_NOP   = 8'h12;
  localparam logic [7:0]  CNT_LAST = 8'(MAX_EXEC_CYCLES - 1);
  localparam logic [15:0] VEC_LO_A = RESET_VECTOR + 16'd1;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  post_q, post_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;

  // Opcodes handed to regmove; everything else except NOP is a trap.
  function automatic logic is_regmove(input logic [7:0] op);
    return (op == 8'h1E) || (op == 8'h1F) || (op == 8'h34) ||
           (op == 8'h35) || (op == 8'h36) || (op == 8'h37);
  endfunction

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= ST_VEC_HI;
      pc_q      <= 16'h0000;
      ir_q      <= 8'h00;
      post_q    <= 8'h00;
      cnt_q     <= 8'h00;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      post_q    <= post_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    post_d    = post_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    addr      = pc_q;
    bus_own   = 1'b0;
    start     = 1'b0;

    case (state_q)
      ST_VEC_HI: begin
        addr    = RESET_VECTOR;
        bus_own = 1'b1;
        pc_d    = {din, pc_q[7:0]};
        state_d = ST_VEC_LO;
      end

      ST_VEC_LO: begin
        addr    = VEC_LO_A;
        bus_own = 1'b1;
        pc_d    = {pc_q[15:8], din};
        state_d = ST_FETCH_OP;
      end

      ST_FETCH_OP: begin
        bus_own = 1'b1;
        ir_d    = din;
        pc_d    = pc_q + 16'd1;
        if (is_regmove(din)) begin
          state_d = ST_FETCH_POST;
        end else if (din == OP_NOP) begin
          // NOP retires here and the next opcode is fetched straight away.
          count_d = count_q + 16'd1;
          state_d = ST_FETCH_OP;
        end else begin
          illegal_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_FETCH_POST: begin
        bus_own = 1'b1;
        post_d  = din;
        pc_d    = pc_q + 16'd1;
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        start   = 1'b1;
        cnt_d   = 8'h00;
        if (pc_load_en) begin
          pc_d = pc_load;
        end
        state_d = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 8'd1;
        // A load in the done cycle still lands, so PULS PC style
        // instructions redirect the very next fetch.
        if (pc_load_en) begin
          pc_d = pc_load;
        end
        if (done) begin
          count_d = count_q + 16'd1;
          state_d = ST_FETCH_OP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        // Unused encoding: treat as a hard trap rather than resuming.
        halted_d = 1'b1;
        state_d  = ST_HALT;
      end
    endcase
  end

  assign data_rw_n   = 1'b1;
  assign ir_out      = ir_q;
  assign post_out    = post_q;
  assign pc_out      = pc_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_m6809_core_fetch.sv
// Testbench for m6809_core_fetch: memory model, regmove responder, program
// interpreter reference model and a start-pulse scoreboard.
module tb_m6809_core_fetch;
  localparam int MAX = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] addr;
  logic        data_rw_n;
  logic        bus_own;
  logic [7:0]  din;
  logic [7:0]  ir_out;
  logic [7:0]  post_out;
  logic [15:0] pc_out;
  logic        start;
  logic        done = 1'b0;
  logic        pc_load_en = 1'b0;
  logic [15:0] pc_load = 16'h0000;
  logic        halted;
  logic        illegal;
  logic        timeout;
  logic [15:0] instr_count;
  logic [2:0]  state_dbg;

  logic [7:0] mem [0:65535];
  assign din = mem[addr];

  m6809_core_fetch #(
    .RESET_VECTOR   (16'hFFFE),
    .MAX_EXEC_CYCLES(MAX)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .addr       (addr),
    .data_rw_n  (data_rw_n),
    .bus_own    (bus_own),
    .din        (din),
    .ir_out     (ir_out),
    .post_out   (post_out),
    .pc_out     (pc_out),
    .start      (start),
    .done       (done),
    .pc_load_en (pc_load_en),
    .pc_load    (pc_load),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout),
    .instr_count(instr_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse must match the next predicted issue.
  always @(negedge clk) begin
    if (reset_b === 1'b1 && start === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 48'(start), 48'h0);
      end else begin
        chk("issue", {ir_out, post_out, pc_out, instr_count}, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // Interprets the program in memory: NOPs retire, register-move opcodes
  // consume a post-byte and issue, anything else traps.
  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  logic [7:0]  m_op;
  bit          m_illegal;

  function automatic bit is_rm(input logic [7:0] b);
    return b inside {8'h1E, 8'h1F, 8'h34, 8'h35, 8'h36, 8'h37};
  endfunction

  task automatic model_walk();
    logic [7:0] post;
    for (int n = 0; n < 70000; n++) begin
      m_op = mem[m_pc];
      m_pc = m_pc + 16'd1;
      if (m_op == 8'h12) begin
        m_cnt = m_cnt + 16'd1;
      end else if (is_rm(m_op)) begin
        post = mem[m_pc];
        m_pc = m_pc + 16'd1;
        exp_q.push_back({m_op, post, m_pc, m_cnt});
        return;
      end else begin
        m_illegal = 1'b1;
        return;
      end
    end
  endtask

  task automatic model_reset();
    chk("leftover_expect", 48'(exp_q.size()), 48'h0);
    exp_q.delete();
    m_pc      = {mem[16'hFFFE], mem[16'hFFFF]};
    m_cnt     = 16'h0000;
    m_illegal = 1'b0;
    model_walk();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h86;
  endtask

  task automatic do_reset();
    reset_b    = 1'b0;
    done       = 1'b0;
    pc_load_en = 1'b0;
    pc_load    = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_addr", 48'(addr), 48'hFFFE);
    chk("rst_pc", 48'(pc_out), 48'h0);
    chk("rst_ir_post", 48'({ir_out, post_out}), 48'h0);
    chk("rst_ctl", 48'({bus_own, data_rw_n, start, halted, illegal, timeout}), 48'b110000);
    chk("rst_count", 48'(instr_count), 48'h0);
    model_reset();
    reset_b = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        return;
      end
    end
    chk("start_seen", 48'h0, 48'h1);
  endtask

  // Plays regmove for one instruction. dly >= 1 negedges after start, done
  // is pulsed (optionally with a PC load). Returns at the negedge of the
  // cycle after done, or one later when junk is set.
  task automatic serve(input bit have_start, input int dly, input bit ld,
                       input logic [15:0] ldval, input bit iss_ld,
                       input logic [15:0] iss_val, input bit junk, input bit plant);
    bit ok;
    ok = 1'b1;
    if (!have_start) wait_start(ok);
    if (!ok) return;
    chk("issue_bus_own", 48'(bus_own), 48'h0);
    if (iss_ld) begin
      pc_load_en = 1'b1;
      pc_load    = iss_val;
      m_pc       = iss_val;
    end
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      pc_load_en = 1'b0;
    end
    done  = 1'b1;
    m_cnt = m_cnt + 16'd1;
    if (ld) begin
      pc_load_en = 1'b1;
      pc_load    = ldval;
      m_pc       = ldval;
      if (plant) mem[ldval] = 8'h86;
    end
    chk("exec_bus_own", 48'(bus_own), 48'h0);
    model_walk();
    @(negedge clk);
    done       = 1'b0;
    pc_load_en = 1'b0;
    if (junk) begin
      // FETCH_OP cycle: done and PC loads must both be ignored here.
      done       = 1'b1;
      pc_load_en = 1'b1;
      pc_load    = 16'($urandom);
      @(negedge clk);
      done       = 1'b0;
      pc_load_en = 1'b0;
    end
  endtask

  task automatic check_halt(input bit exp_il, input bit exp_to);
    logic [47:0] snap;
    bit changed;
    repeat (3) @(negedge clk);
    chk("halted", 48'(halted), 48'h1);
    chk("illegal", 48'(illegal), 48'(exp_il));
    chk("timeout", 48'(timeout), 48'(exp_to));
    chk("halt_pc", 48'(pc_out), 48'(m_pc));
    chk("halt_count", 48'(instr_count), 48'(m_cnt));
    chk("halt_bus_own", 48'(bus_own), 48'h0);
    if (exp_il) chk("halt_ir", 48'(ir_out), 48'(m_op));
    snap    = {ir_out, post_out, pc_out, instr_count};
    changed = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (snap !== {ir_out, post_out, pc_out, instr_count} || start || !halted) changed = 1'b1;
    end
    chk("halt_frozen", 48'(changed), 48'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bit ok;
    logic [7:0] fill_tab [7];
    fill_tab = '{8'h12, 8'h1E, 8'h1F, 8'h34, 8'h35, 8'h36, 8'h37};

    // 1: basic issue, reset-to-start latency, done after 3 cycles
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h1200] = 8'h34; mem[16'h1201] = 8'h06;
    do_reset();
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (start) break;
    end
    // fourth negedge after release = fifth cycle counting the release cycle
    chk("reset_to_start", 48'(cyc), 48'd4);
    serve(1'b1, 3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("next_fetch_addr", 48'(addr), 48'h1202);
    chk("next_fetch_own", 48'(bus_own), 48'h1);
    chk("count_after_done", 48'(instr_count), 48'h1);
    check_halt(1'b1, 1'b0);

    // 2: TFR with PC load coinciding with done
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h1200] = 8'h1F; mem[16'h1201] = 8'h89;
    do_reset();
    serve(1'b0, 2, 1'b1, 16'h4000, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("reload_addr", 48'(addr), 48'h4000);
    chk("reload_own", 48'(bus_own), 48'h1);
    check_halt(1'b1, 1'b0);

    // 3: two NOPs then PULS
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h1200] = 8'h12; mem[16'h1201] = 8'h12;
    mem[16'h1202] = 8'h35; mem[16'h1203] = 8'h80;
    do_reset();
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (start) break;
    end
    chk("nop_to_start", 48'(cyc), 48'd6);
    serve(1'b1, 1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_halt(1'b1, 1'b0);

    // 4: illegal first opcode
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    do_reset();
    check_halt(1'b1, 1'b0);

    // 5: missing done -> timeout, late done ignored
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h1200] = 8'h1E; mem[16'h1201] = 8'h01;
    do_reset();
    wait_start(ok);
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) break;
      cyc++;
    end
    chk("timeout_latency", 48'(cyc), 48'(MAX));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check_halt(1'b0, 1'b1);

    // 6: asynchronous reset during WAIT_DONE with done pending
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h00;
    mem[16'h1200] = 8'h34; mem[16'h1201] = 8'h06;
    do_reset();
    wait_start(ok);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset_b = 1'b0;
    done    = 1'b1;
    #1;
    chk("async_addr", 48'(addr), 48'hFFFE);
    chk("async_pc", 48'(pc_out), 48'h0);
    chk("async_ctl", 48'({bus_own, start, halted, ir_out, post_out}), 48'({1'b1, 1'b0, 1'b0, 16'h0}));
    chk("async_count", 48'(instr_count), 48'h0);
    do_reset();
    #1;
    chk("refetch_addr", 48'(addr), 48'hFFFE);
    serve(1'b0, 3, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_halt(1'b1, 1'b0);

    // 7: opcode at FFFF, post-byte wraps to 0000
    clear_mem();
    mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h34;
    mem[16'h1234] = 8'h1F; mem[16'h1235] = 8'h00;
    mem[16'h0000] = 8'h06;
    do_reset();
    serve(1'b0, 1, 1'b1, 16'hFFFF, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("wrap_op_addr", 48'(addr), 48'hFFFF);
    @(negedge clk);
    chk("wrap_post_addr", 48'(addr), 48'h0000);
    serve(1'b0, 2, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_halt(1'b1, 1'b0);

    // 8: random programs with random latency, reloads and ignored strobes
    for (int i = 0; i < 65536; i++) mem[i] = fill_tab[$urandom_range(0, 6)];
    do_reset();
    for (int k = 0; k < 150; k++) begin
      bit last;
      last = (k == 149);
      serve(1'b0, $urandom_range(1, 6),
            last || ($urandom_range(0, 3) == 0), 16'($urandom),
            ($urandom_range(0, 7) == 0), 16'($urandom),
            ($urandom_range(0, 3) == 0), last);
      if (m_illegal) break;
    end
    check_halt(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
